// File: rtl/lfsr_dec_pkg.sv
// Shared definitions for the LFSR count decoder: FSM states and the tap table
// that must match the LFSR up/down counter family exactly.
package lfsr_dec_pkg;

  localparam int MAX_WIDTH = 12;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Bit (t-1) is set for every tap t of the XNOR Fibonacci LFSR of width w.
  function automatic logic [MAX_WIDTH-1:0] tap_mask(input int w);
    case (w)
      2:       tap_mask = 12'h003;
      3:       tap_mask = 12'h006;
      4:       tap_mask = 12'h00C;
      5:       tap_mask = 12'h014;
      6:       tap_mask = 12'h030;
      7:       tap_mask = 12'h060;
      8:       tap_mask = 12'h0B8;
      9:       tap_mask = 12'h110;
      10:      tap_mask = 12'h240;
      11:      tap_mask = 12'h500;
      12:      tap_mask = 12'h829;
      default: tap_mask = 12'h000;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_count_decode_step.sv
// Combinational single step of the XNOR Fibonacci LFSR: dir=0 gives the
// successor of q, dir=1 gives its predecessor.
module lfsr_step
  import lfsr_dec_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             dir,
  input  logic [width-1:0] q,
  output logic [width-1:0] q_nxt
);

  localparam logic [MAX_WIDTH-1:0] MASK     = tap_mask(width);
  localparam logic [width-1:0]     FWD_MASK = MASK[width-1:0];
  // Taps t<width seen from the successor sit one bit higher; the top tap drops out.
  localparam logic [width-1:0]     BWD_MASK = {MASK[width-2:0], 1'b0};

  always_comb begin
    q_nxt = q;
    if (!dir) begin
      q_nxt = {q[width-2:0], ~^(q & FWD_MASK)};
    end else begin
      q_nxt = {~(q[0] ^ (^(q & BWD_MASK))), q[width-1:1]};
    end
  end

endmodule

// File: rtl/lfsr_count_decode.sv
// Recovers the binary index of an LFSR state by stepping a local LFSR from the
// all-zeros seed. Define LFSR_DEC_BIDIR_EN to add a backward engine that halves latency.
module lfsr_count_decode
  import lfsr_dec_pkg::*;
#(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [width-1:0] lfsr_value,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [width-1:0] count
);

  if (width < 2 || width > MAX_WIDTH) begin : g_bad_width
    $error("lfsr_count_decode: width must be in 2..12");
  end

  // Highest reachable index 2^width-2; idx never advances past it.
  localparam logic [width-1:0] IDX_LAST = {{(width-1){1'b1}}, 1'b0};

  state_t           state, state_nxt;
  logic [width-1:0] target;
  logic [width-1:0] fwd, fwd_nxt;
  logic [width-1:0] idx;
  logic [width-1:0] count_q;
  logic             found_q;

  logic             accept;
  logic             advance;
  logic             finish;
  logic             res_found;
  logic [width-1:0] res_count;
  logic             last;

  lfsr_step #(.width(width)) u_fwd_step (
    .dir   (1'b0),
    .q     (fwd),
    .q_nxt (fwd_nxt)
  );

`ifdef LFSR_DEC_BIDIR_EN
  // The predecessor of the all-zeros seed is 1 followed by zeros for every width.
  localparam logic [width-1:0] BWD_SEED = {1'b1, {(width-1){1'b0}}};

  logic [width-1:0] bwd, bwd_nxt;

  lfsr_step #(.width(width)) u_bwd_step (
    .dir   (1'b1),
    .q     (bwd),
    .q_nxt (bwd_nxt)
  );

  assign last = (idx >= (IDX_LAST - idx));
`else
  assign last = (idx == IDX_LAST);
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    advance   = 1'b0;
    finish    = 1'b0;
    res_found = 1'b0;
    res_count = '0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        // Match checks come before the terminal check so the last index is tested.
        if (fwd == target) begin
          finish    = 1'b1;
          res_found = 1'b1;
          res_count = idx;
          state_nxt = DONE;
`ifdef LFSR_DEC_BIDIR_EN
        end else if (bwd == target) begin
          finish    = 1'b1;
          res_found = 1'b1;
          res_count = IDX_LAST - idx;
          state_nxt = DONE;
`endif
        end else if (last) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          advance = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SEARCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      target  <= '0;
      fwd     <= '0;
      idx     <= '0;
      count_q <= '0;
      found_q <= 1'b0;
`ifdef LFSR_DEC_BIDIR_EN
      bwd     <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        target <= lfsr_value;
        fwd    <= '0;
        idx    <= '0;
`ifdef LFSR_DEC_BIDIR_EN
        bwd    <= BWD_SEED;
`endif
      end else if (advance) begin
        fwd <= fwd_nxt;
        idx <= idx + 1'b1;
`ifdef LFSR_DEC_BIDIR_EN
        bwd <= bwd_nxt;
`endif
      end
      if (finish) begin
        count_q <= res_count;
        found_q <= res_found;
      end
    end
  end

  assign busy  = (state == SEARCH);
  assign done  = (state == DONE);
  assign found = found_q;
  assign count = count_q;

endmodule

// File: tb/tb_lfsr_count_decode.sv
// Directed bench for lfsr_count_decode at width=8; expected indices and
// latencies are hand-derived from the XNOR LFSR sequence 00,01,03,07,0F,...
module tb_lfsr_count_decode;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] lfsr_value;
  logic       busy;
  logic       done;
  logic       found;
  logic [7:0] count;

  int n_cmp;
  int n_err;

  lfsr_count_decode #(.width(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .lfsr_value (lfsr_value),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef LFSR_DEC_BIDIR_EN
  localparam int LAT_80 = 2;
  localparam int LAT_FF = 129;
`else
  localparam int LAT_80 = 256;
  localparam int LAT_FF = 256;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Edge 0 launches start, edge 1 accepts it; done is expected at edge exp_lat.
  task automatic run_search(input string tag, input logic [7:0] v, input logic exp_found,
                            input logic [7:0] exp_cnt, input int exp_lat, input bit glitch);
    int e;
    @(posedge clk); #1;
    start      = 1'b1;
    lfsr_value = v;
    @(posedge clk); #1;
    start      = 1'b0;
    lfsr_value = ~v;
    e = 1;
    check({tag, "_busy_start"}, busy, 1);
    while (!done && e < 300) begin
      if (glitch && e == 3) begin
        start      = 1'b1;
        lfsr_value = 8'h07;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      e++;
      if (!done) check({tag, "_busy_search"}, busy, 1);
    end
    start = 1'b0;
    check({tag, "_latency"}, e, exp_lat);
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_done"}, busy, 0);
    check({tag, "_found"}, found, exp_found);
    check({tag, "_count"}, count, exp_cnt);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_count_hold"}, count, exp_cnt);
    check({tag, "_found_hold"}, found, exp_found);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b1;
    start      = 1'b0;
    lfsr_value = 8'h00;
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_count", count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_search("v00", 8'h00, 1'b1, 8'd0, 2, 1'b0);
    run_search("v0F", 8'h0F, 1'b1, 8'd4, 6, 1'b0);

    // Asynchronous reset in the middle of a search clears everything at once.
    @(posedge clk); #1;
    start      = 1'b1;
    lfsr_value = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_pre", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_done", done, 0);
    check("mid_found", found, 0);
    check("mid_count", count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_search("v80", 8'h80, 1'b1, 8'd254, LAT_80, 1'b0);
    run_search("vFF", 8'hFF, 1'b0, 8'd0, LAT_FF, 1'b0);
    run_search("ign", 8'h0F, 1'b1, 8'd4, 6, 1'b1);

    // start held high: second search accepted on the DONE cycle, captures 0x03.
    @(posedge clk); #1;
    start      = 1'b1;
    lfsr_value = 8'h01;
    @(posedge clk); #1;
    lfsr_value = 8'h03;
    for (int e = 2; e <= 8; e++) begin
      @(posedge clk); #1;
      check("b2b_done", done, (e == 3 || e == 7));
      check("b2b_busy", busy, (e == 2 || e == 4 || e == 5 || e == 6));
      if (e == 3) check("b2b_count1", count, 8'd1);
      if (e == 7) begin
        check("b2b_count2", count, 8'd2);
        start = 1'b0;
      end
    end
    check("b2b_found", found, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
